// File: rtl/laser_pkg.sv
// Shared constants, coordinate type and FSM state encodings for the laser
// treatment core and its coverage scorer.
package laser_pkg;

   localparam int LASER_NPTS = 40;
   localparam int LASER_R2   = 16;

   typedef logic [3:0] coord_t;

   typedef enum logic {
      CAP,
      FULL
   } cap_state_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      OUT
   } sc_state_t;

endpackage

// File: rtl/laser_in_circle.sv
// Combinational hit test: is point (px,py) within squared radius R2 of (cx,cy).
module laser_in_circle
   import laser_pkg::*;
#(
   parameter int R2 = LASER_R2
) (
   input  logic [3:0] cx,
   input  logic [3:0] cy,
   input  logic [3:0] px,
   input  logic [3:0] py,
   output logic       hit
);

   localparam logic [8:0] R2_L = 9'(R2);

   logic [4:0] diff_x;
   logic [4:0] diff_y;
   logic [3:0] dx;
   logic [3:0] dy;
   logic [7:0] sq_x;
   logic [7:0] sq_y;
   logic [8:0] dist2;

   assign diff_x = {1'b0, cx} - {1'b0, px};
   assign diff_y = {1'b0, cy} - {1'b0, py};
   // Bit 4 of the 5-bit difference is the borrow, i.e. the sign.
   assign dx     = diff_x[4] ? (4'd0 - diff_x[3:0]) : diff_x[3:0];
   assign dy     = diff_y[4] ? (4'd0 - diff_y[3:0]) : diff_y[3:0];
   assign sq_x   = {4'd0, dx} * {4'd0, dx};
   assign sq_y   = {4'd0, dy} * {4'd0, dy};
   assign dist2  = {1'b0, sq_x} + {1'b0, sq_y};
   assign hit    = (dist2 <= R2_L);

endmodule

// File: rtl/laser_cov_scorer.sv
// Snoops the core's point stream into a double-buffered point store and
// re-scores the core's two chosen circle centres when the core signals DONE.
module laser_cov_scorer
   import laser_pkg::*;
#(
   parameter int NPTS = LASER_NPTS,
   parameter int R2   = LASER_R2
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [3:0] X,
   input  logic [3:0] Y,
   input  logic [3:0] C1X,
   input  logic [3:0] C1Y,
   input  logic [3:0] C2X,
   input  logic [3:0] C2Y,
   input  logic       DONE,
   output logic [5:0] SCORE,
   output logic [5:0] C1HIT,
   output logic [5:0] C2HIT,
   output logic       VALID,
   output logic       ERR
);

   localparam int            IW   = $clog2(NPTS);
   localparam logic [IW-1:0] LAST = IW'(NPTS - 1);

   logic [7:0] bank_mem [2][NPTS];

   cap_state_t    cap_state_reg, cap_state_next;
   logic [IW-1:0] cidx_reg, cidx_next;
   logic          wb_reg, wb_next;
   logic          cap_we, cap_accept, cap_err;

   sc_state_t       sc_state_reg, sc_state_next;
   logic [IW-1:0]   sidx_reg, sidx_next;
   logic            sb_reg, sb_next;
   logic [1:0][7:0] cen_reg, cen_next;
   logic [5:0]      acc_u_reg, acc_u_next;
   logic [5:0]      acc_1_reg, acc_1_next;
   logic [5:0]      acc_2_reg, acc_2_next;
   logic [5:0]      score_reg, score_next;
   logic [5:0]      c1hit_reg, c1hit_next;
   logic [5:0]      c2hit_reg, c2hit_next;
   logic            valid_reg, valid_next;
   logic            err_reg, err_next;

   logic [7:0] pt;
   logic [1:0] hit;
   logic       start, sc_err;
   logic [5:0] sum_u, sum_1, sum_2;

   // ---------------- capture ----------------
   always_comb begin
      cap_state_next = cap_state_reg;
      cidx_next      = cidx_reg;
      wb_next        = wb_reg;
      cap_we         = 1'b0;
      cap_accept     = 1'b0;
      cap_err        = 1'b0;
      case (cap_state_reg)
         CAP: begin
            if (DONE) begin
               cap_err   = 1'b1;
               cidx_next = '0;
            end else begin
               cap_we = 1'b1;
               if (cidx_reg == LAST) begin
                  cidx_next      = '0;
                  cap_state_next = FULL;
               end else begin
                  cidx_next = cidx_reg + IW'(1);
               end
            end
         end
         FULL: begin
            if (DONE) begin
               cap_accept     = 1'b1;
               wb_next        = ~wb_reg;
               cap_state_next = CAP;
            end
         end
         default: cap_state_next = CAP;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (cap_we)
         bank_mem[wb_reg][cidx_reg] <= {X, Y};
   end

   // ---------------- scoring ----------------
   assign pt = bank_mem[sb_reg][sidx_reg];

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_circle
         laser_in_circle #(.R2(R2)) u_circle (
            .cx  (cen_reg[gi][7:4]),
            .cy  (cen_reg[gi][3:0]),
            .px  (pt[7:4]),
            .py  (pt[3:0]),
            .hit (hit[gi])
         );
      end
   endgenerate

   // OUT has already registered its result, so a DONE landing there starts
   // the next run; only a DONE during RUN would clobber work in progress.
   assign start  = cap_accept && (sc_state_reg != RUN);
   assign sc_err = cap_accept && (sc_state_reg == RUN);

   assign sum_u = acc_u_reg + 6'(hit[0] | hit[1]);
   assign sum_1 = acc_1_reg + 6'(hit[0]);
   assign sum_2 = acc_2_reg + 6'(hit[1]);

   always_comb begin
      sc_state_next = sc_state_reg;
      sidx_next     = sidx_reg;
      sb_next       = sb_reg;
      cen_next      = cen_reg;
      acc_u_next    = acc_u_reg;
      acc_1_next    = acc_1_reg;
      acc_2_next    = acc_2_reg;
      score_next    = score_reg;
      c1hit_next    = c1hit_reg;
      c2hit_next    = c2hit_reg;
      valid_next    = 1'b0;
      err_next      = err_reg | cap_err | sc_err;
      if (start) begin
         sc_state_next = RUN;
         sidx_next     = '0;
         sb_next       = wb_reg;
         cen_next      = {C2X, C2Y, C1X, C1Y};
         acc_u_next    = '0;
         acc_1_next    = '0;
         acc_2_next    = '0;
      end else if (sc_state_reg == RUN) begin
         acc_u_next = sum_u;
         acc_1_next = sum_1;
         acc_2_next = sum_2;
         sidx_next  = sidx_reg + IW'(1);
         if (sidx_reg == LAST) begin
            sidx_next     = '0;
            sc_state_next = OUT;
            score_next    = sum_u;
            c1hit_next    = sum_1;
            c2hit_next    = sum_2;
            valid_next    = 1'b1;
         end
      end else if (sc_state_reg == OUT) begin
         sc_state_next = IDLE;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cap_state_reg <= CAP;
         cidx_reg      <= '0;
         wb_reg        <= 1'b0;
         sc_state_reg  <= IDLE;
         sidx_reg      <= '0;
         sb_reg        <= 1'b0;
         cen_reg       <= '0;
         acc_u_reg     <= '0;
         acc_1_reg     <= '0;
         acc_2_reg     <= '0;
         score_reg     <= '0;
         c1hit_reg     <= '0;
         c2hit_reg     <= '0;
         valid_reg     <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         cap_state_reg <= cap_state_next;
         cidx_reg      <= cidx_next;
         wb_reg        <= wb_next;
         sc_state_reg  <= sc_state_next;
         sidx_reg      <= sidx_next;
         sb_reg        <= sb_next;
         cen_reg       <= cen_next;
         acc_u_reg     <= acc_u_next;
         acc_1_reg     <= acc_1_next;
         acc_2_reg     <= acc_2_next;
         score_reg     <= score_next;
         c1hit_reg     <= c1hit_next;
         c2hit_reg     <= c2hit_next;
         valid_reg     <= valid_next;
         err_reg       <= err_next;
      end
   end

   assign SCORE = score_reg;
   assign C1HIT = c1hit_reg;
   assign C2HIT = c2hit_reg;
   assign VALID = valid_reg;
   assign ERR   = err_reg;

endmodule
